prime_scroll_ctrl: RTL

PRIME_SCROLL_CTRL -- requirements
Module: prime_scroll_ctrl

---
 rtl/prime_scroll_pkg.sv | 29 ++
 rtl/prime_scroll_ctrl_tick.sv | 47 ++++
 rtl/prime_scroll_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/prime_scroll_pkg.sv
// Shared types, widths and defaults for the prime-number scrolling display controller.
package prime_scroll_pkg;

  localparam int IDX_W           = 8;
  localparam int VAL_W           = 10;
  localparam int TICK_CYCLES_DEF = 70000000;
  localparam int MAX_PRIMES_DEF  = 172;

  typedef enum logic [2:0] {
    IDLE,
    SIEVE,
    STORE,
    FETCH_A,
    FETCH_B,
    SHOW
  } state_t;

  // Table tags are 1-based and wrap within 1..cnt.
  function automatic logic [IDX_W-1:0] next_tag(input logic [IDX_W-1:0] t,
                                               input logic [IDX_W-1:0] cnt);
    return (t == cnt) ? IDX_W'(1) : t + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] prev_tag(input logic [IDX_W-1:0] t,
                                               input logic [IDX_W-1:0] cnt);
    return (t == IDX_W'(1)) ? cnt : t - IDX_W'(1);
  endfunction

endpackage

// File: rtl/prime_scroll_ctrl_tick.sv
// Display step timer with optional pause toggle; pause support is built only when
// PRIME_SCROLL_PAUSE_EN is defined, otherwise the pause input is ignored.
module prime_tick_gen
  import prime_scroll_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pause,
  output logic tick
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             paused;

`ifdef PRIME_SCROLL_PAUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      paused <= 1'b0;
    else if (pause)
      paused <= ~paused;
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign paused       = 1'b0;
`endif

  // The pre-toggle paused value gates the tick, so a pause press on the terminal
  // count still lets that advance happen.
  assign tick = enable && !paused && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!enable)
      cnt <= '0;
    else if (!paused)
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/prime_scroll_ctrl.sv
// Builds the prime table via sieve/compaction handshakes, then scrolls an adjacent pair
// of primes on the LCD. Pause is available only with PRIME_SCROLL_PAUSE_EN defined.
module prime_scroll_ctrl
  import prime_scroll_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int MAX_PRIMES  = MAX_PRIMES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_dir,
  input  logic             btn_pause,
  output logic             sieve_start,
  input  logic             sieve_done,
  output logic             store_start,
  input  logic             store_done,
  input  logic [IDX_W-1:0] store_count,
  output logic             rd_req,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             rd_ack,
  input  logic [VAL_W-1:0] rd_data,
  output logic             disp_valid,
  output logic [IDX_W-1:0] disp_tag_a,
  output logic [VAL_W-1:0] disp_val_a,
  output logic [IDX_W-1:0] disp_tag_b,
  output logic [VAL_W-1:0] disp_val_b,
  output logic             busy
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_PRIMES);

  state_t           state, state_n;
  logic [IDX_W-1:0] tag, count, clamped, tag_next, tag_prev;
  logic [VAL_W-1:0] val_a;
  logic             dir, tick;
  logic             sieve_start_n, store_start_n, latch_count, issue, cap_a, cap_b, advance;

  assign clamped  = (store_count > MAX_IDX) ? MAX_IDX : store_count;
  assign tag_next = next_tag(tag, count);
  assign tag_prev = prev_tag(tag, count);

  // Gated by reset so every output reads 0 while reset is held.
  assign busy = !reset && (state == IDLE || state == SIEVE || state == STORE);

  prime_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state == SHOW),
    .pause  (btn_pause),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Done strobes are ignored while our own start pulse is still high.
  always_comb begin
    state_n       = state;
    sieve_start_n = 1'b0;
    store_start_n = 1'b0;
    latch_count   = 1'b0;
    issue         = 1'b0;
    cap_a         = 1'b0;
    cap_b         = 1'b0;
    advance       = 1'b0;
    case (state)
      IDLE: begin
        sieve_start_n = 1'b1;
        state_n       = SIEVE;
      end
      SIEVE: begin
        if (!sieve_start && sieve_done) begin
          store_start_n = 1'b1;
          state_n       = STORE;
        end
      end
      STORE: begin
        if (!store_start && store_done) begin
          latch_count = 1'b1;
          state_n     = (clamped < IDX_W'(2)) ? IDLE : FETCH_A;
        end
      end
      FETCH_A: begin
        if (!rd_req)
          issue = 1'b1;
        else if (rd_ack) begin
          cap_a   = 1'b1;
          state_n = FETCH_B;
        end
      end
      FETCH_B: begin
        if (!rd_req)
          issue = 1'b1;
        else if (rd_ack) begin
          cap_b   = 1'b1;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (tick) begin
          advance = 1'b1;
          state_n = FETCH_A;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sieve_start <= 1'b0;
      store_start <= 1'b0;
      count       <= '0;
      tag         <= IDX_W'(1);
      dir         <= 1'b0;
      rd_req      <= 1'b0;
      rd_idx      <= '0;
      val_a       <= '0;
      disp_valid  <= 1'b0;
      disp_tag_a  <= '0;
      disp_val_a  <= '0;
      disp_tag_b  <= '0;
      disp_val_b  <= '0;
    end else begin
      sieve_start <= sieve_start_n;
      store_start <= store_start_n;
      if (btn_dir)
        dir <= ~dir;
      if (latch_count)
        count <= clamped;
      if (issue) begin
        rd_req <= 1'b1;
        rd_idx <= (state == FETCH_A) ? tag : tag_next;
      end
      if (cap_a) begin
        rd_req <= 1'b0;
        val_a  <= rd_data;
      end
      // The shown pair only changes once both reads are in hand.
      if (cap_b) begin
        rd_req     <= 1'b0;
        disp_valid <= 1'b1;
        disp_tag_a <= tag;
        disp_val_a <= val_a;
        disp_tag_b <= tag_next;
        disp_val_b <= rd_data;
      end
      if (advance)
        tag <= dir ? tag_prev : tag_next;
    end
  end

endmodule
